// File: rtl/alarm_pkg.sv
// alarm_pkg: shared edit states, field limits and field widths for the alarm setter.
package alarm_pkg;
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SET_HOURS   = 2'd1,
        SET_MINUTES = 2'd2
    } state_t;
    localparam int HOURS_MAX   = 23;
    localparam int MINUTES_MAX = 59;
    localparam int HOURS_W     = 5;
    localparam int MINUTES_W   = 6;
endpackage

// File: rtl/alarm_field_counter.sv
// alarm_field_counter: wrapping up/down field counter with load; load wins, inc+dec together is a no-op.
module alarm_field_counter #(
    parameter int MAX     = 59,
    parameter int W       = 6,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value
);
    always_ff @(posedge clk) begin
        if (!rst_n)
            value <= W'(RST_VAL);
        else if (load)
            value <= load_val;
        else if (inc && !dec)
            value <= (value == W'(MAX)) ? '0 : value + 1'b1;
        else if (dec && !inc)
            value <= (value == '0) ? W'(MAX) : value - 1'b1;
    end
endmodule

// File: rtl/alarm_setter.sv
// alarm_setter: mode-button driven hours/minutes alarm editor with shadow registers and commit on exit.
// Optional inactivity timeout that abandons an edit is built when ALARM_SET_TIMEOUT_EN is defined.
module alarm_setter
    import alarm_pkg::*;
#(
    parameter int TIMEOUT_S   = 10,
    parameter int RST_HOURS   = 6,
    parameter int RST_MINUTES = 0
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 clk_1hz_en,
    input  logic                 mode_btn,
    input  logic                 inc_btn,
    input  logic                 dec_btn,
    input  logic                 en_toggle_btn,
    output logic [HOURS_W-1:0]   alarm_hours_out,
    output logic [MINUTES_W-1:0] alarm_minutes_out,
    output logic                 alarm_enable_out,
    output logic [HOURS_W-1:0]   edit_hours_out,
    output logic [MINUTES_W-1:0] edit_minutes_out,
    output logic [1:0]           set_state_out
);
    state_t state, next_state;
    logic   editing, timeout, load;

    assign editing       = state != IDLE;
    assign set_state_out = state;
    // Shadows track the committed value in IDLE, so entering an edit copies it on the same edge.
    assign load          = !editing || timeout;

    always_ff @(posedge sys_clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (mode_btn)
            next_state = (state == IDLE) ? SET_HOURS : (state == SET_HOURS) ? SET_MINUTES : IDLE;
        else if (timeout)
            next_state = IDLE;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            alarm_hours_out   <= HOURS_W'(RST_HOURS);
            alarm_minutes_out <= MINUTES_W'(RST_MINUTES);
            alarm_enable_out  <= 1'b0;
        end else begin
            alarm_enable_out <= alarm_enable_out ^ en_toggle_btn;
            if (state == SET_MINUTES && mode_btn) begin
                alarm_hours_out   <= edit_hours_out;
                alarm_minutes_out <= edit_minutes_out;
            end
        end
    end

    alarm_field_counter #(.MAX(HOURS_MAX), .W(HOURS_W), .RST_VAL(RST_HOURS)) u_hours (
        .clk      (sys_clk),
        .rst_n    (rst_n),
        .load     (load),
        .inc      (state == SET_HOURS && !mode_btn && inc_btn),
        .dec      (state == SET_HOURS && !mode_btn && dec_btn),
        .load_val (alarm_hours_out),
        .value    (edit_hours_out)
    );

    alarm_field_counter #(.MAX(MINUTES_MAX), .W(MINUTES_W), .RST_VAL(RST_MINUTES)) u_minutes (
        .clk      (sys_clk),
        .rst_n    (rst_n),
        .load     (load),
        .inc      (state == SET_MINUTES && !mode_btn && inc_btn),
        .dec      (state == SET_MINUTES && !mode_btn && dec_btn),
        .load_val (alarm_minutes_out),
        .value    (edit_minutes_out)
    );

`ifdef ALARM_SET_TIMEOUT_EN
    logic [5:0] secs;
    logic       activity;

    assign activity = mode_btn || inc_btn || dec_btn;
    assign timeout  = editing && clk_1hz_en && !activity && secs == 6'(TIMEOUT_S - 1);

    always_ff @(posedge sys_clk) begin
        if (!rst_n || !editing || activity || timeout)
            secs <= '0;
        else if (clk_1hz_en)
            secs <= secs + 1'b1;
    end
`else
    logic unused_1hz;
    assign unused_1hz = clk_1hz_en | (TIMEOUT_S < 2);
    assign timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_alarm_setter.sv
// tb_alarm_setter: directed and random stimulus checked against a behavioural alarm-setter model.
module tb_alarm_setter;
    localparam int TO = 10;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_1hz_en = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0, en_toggle_btn = 1'b0;
    logic [4:0] alarm_hours_out, edit_hours_out;
    logic [5:0] alarm_minutes_out, edit_minutes_out;
    logic       alarm_enable_out;
    logic [1:0] set_state_out;

    int checks = 0, failures = 0;
    int st, h, m, en, eh, em, cnt;

    alarm_setter #(.TIMEOUT_S(TO), .RST_HOURS(6), .RST_MINUTES(0)) dut (
        .sys_clk           (sys_clk),
        .rst_n             (rst_n),
        .clk_1hz_en        (clk_1hz_en),
        .mode_btn          (mode_btn),
        .inc_btn           (inc_btn),
        .dec_btn           (dec_btn),
        .en_toggle_btn     (en_toggle_btn),
        .alarm_hours_out   (alarm_hours_out),
        .alarm_minutes_out (alarm_minutes_out),
        .alarm_enable_out  (alarm_enable_out),
        .edit_hours_out    (edit_hours_out),
        .edit_minutes_out  (edit_minutes_out),
        .set_state_out     (set_state_out)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit md, input bit i, input bit d, input bit t, input bit p);
        if (!r) begin
            st = 0; h = 6; m = 0; en = 0; eh = 6; em = 0; cnt = 0;
            return;
        end
        en = en ^ int'(t);
        if (md) begin
            cnt = 0;
            if (st == 0) begin eh = h; em = m; st = 1; end
            else if (st == 1) st = 2;
            else begin h = eh; m = em; st = 0; end
        end else if (st != 0 && (i || d)) begin
            cnt = 0;
            if (i != d) begin
                if (st == 1) eh = (eh + (i ? 1 : 23)) % 24;
                else em = (em + (i ? 1 : 59)) % 60;
            end
        end else if (st != 0 && p) begin
`ifdef ALARM_SET_TIMEOUT_EN
            cnt++;
            if (cnt >= TO) begin st = 0; eh = h; em = m; cnt = 0; end
`endif
        end
    endtask

    task automatic step(input bit r, input bit md, input bit i, input bit d, input bit t, input bit p);
        @(negedge sys_clk);
        rst_n = r; mode_btn = md; inc_btn = i; dec_btn = d; en_toggle_btn = t; clk_1hz_en = p;
        @(posedge sys_clk);
        model(r, md, i, d, t, p);
        #1;
        check("state", set_state_out, st);
        check("alarm_h", alarm_hours_out, h);
        check("alarm_m", alarm_minutes_out, m);
        check("enable", alarm_enable_out, en);
        check("edit_h", edit_hours_out, eh);
        check("edit_m", edit_minutes_out, em);
    endtask

    task automatic press(input bit md, input bit i, input bit d);
        step(1, md, i, d, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("rst_state", set_state_out, 0);
        check("rst_h", alarm_hours_out, 6);
        check("rst_m", alarm_minutes_out, 0);
        check("rst_en", alarm_enable_out, 0);
        press(0, 1, 0);
        check("idle_inc_ignored", edit_hours_out, 6);
        // 06:00 -> 09:58
        press(1, 0, 0);
        repeat (3) press(0, 1, 0);
        check("edit_h_9", edit_hours_out, 9);
        press(1, 0, 0);
        repeat (2) press(0, 0, 1);
        check("edit_m_58", edit_minutes_out, 58);
        check("held_h", alarm_hours_out, 6);
        check("held_m", alarm_minutes_out, 0);
        press(1, 0, 0);
        check("commit_h", alarm_hours_out, 9);
        check("commit_m", alarm_minutes_out, 58);
        check("commit_state", set_state_out, 0);
        // wrap cases
        press(1, 0, 0);
        repeat (14) press(0, 1, 0);
        check("edit_h_23", edit_hours_out, 23);
        press(0, 1, 0);
        check("hours_wrap", edit_hours_out, 0);
        press(1, 0, 0);
        repeat (2) press(0, 1, 0);
        check("min_wrap_up", edit_minutes_out, 0);
        press(0, 0, 1);
        check("min_wrap_dn", edit_minutes_out, 59);
        check("min_wrap_h", edit_hours_out, 0);
        // coincident buttons
        press(0, 1, 1);
        check("inc_dec_nochg", edit_minutes_out, 59);
        press(1, 1, 0);
        check("mode_inc_state", set_state_out, 0);
        check("mode_inc_m", alarm_minutes_out, 59);
        press(1, 0, 0);
        press(1, 1, 0);
        check("mode_inc_h_state", set_state_out, 2);
        check("mode_inc_h", edit_hours_out, 0);
        // enable toggle during edit
        step(1, 0, 0, 0, 1, 0);
        check("toggle_en", alarm_enable_out, 1);
        check("toggle_state", set_state_out, 2);
        // reset mid-edit
        press(0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        check("midrst_state", set_state_out, 0);
        check("midrst_h", alarm_hours_out, 6);
        check("midrst_m", alarm_minutes_out, 0);
        check("midrst_en", alarm_enable_out, 0);
        // inactivity
        press(1, 0, 0);
        press(0, 1, 0);
        check("to_edit_7", edit_hours_out, 7);
`ifdef ALARM_SET_TIMEOUT_EN
        repeat (9) step(1, 0, 0, 0, 0, 1);
        check("to_not_yet", set_state_out, 1);
        step(1, 0, 0, 0, 0, 1);
        check("to_idle", set_state_out, 0);
        check("to_h", alarm_hours_out, 6);
        check("to_edit_h", edit_hours_out, 6);
        press(1, 0, 0);
        press(0, 1, 0);
        repeat (8) step(1, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 1);
        repeat (9) step(1, 0, 0, 0, 0, 1);
        check("to_restart", set_state_out, 1);
        step(1, 0, 0, 0, 0, 1);
        check("to_restart_idle", set_state_out, 0);
`else
        repeat (12) step(1, 0, 0, 0, 0, 1);
        check("no_timeout", set_state_out, 1);
        check("no_timeout_h", edit_hours_out, 7);
`endif
        repeat (600)
            step($urandom_range(49) != 0, $urandom_range(9) == 0, $urandom_range(7) == 0,
                 $urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(1) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
